// File: rtl/int_div_iterative.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with val/rdy request and response streams.
module int_div_iterative #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [2*p_nbits:0]     istream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [2*p_nbits-1:0]   ostream_msg
);

  localparam int CW = $clog2(p_nbits + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [p_nbits:0]   r;
  logic [p_nbits-1:0] q, d, raw_a, res_q, res_r;
  logic               neg_q, neg_r, div0;

  logic               is_signed, sa, sb, accept;
  logic [p_nbits-1:0] op_a, op_b;
  logic [p_nbits:0]   r_sh, trial, r_step;
  logic [p_nbits-1:0] q_step, res_q_nxt, res_r_nxt;

  function automatic logic [p_nbits-1:0] cond_neg(input logic en, input logic [p_nbits-1:0] x);
    return en ? -x : x;
  endfunction

  assign is_signed = istream_msg[2*p_nbits];
  assign op_a      = istream_msg[2*p_nbits-1:p_nbits];
  assign op_b      = istream_msg[p_nbits-1:0];
  assign sa        = is_signed & op_a[p_nbits-1];
  assign sb        = is_signed & op_b[p_nbits-1];
  assign accept    = istream_val & istream_rdy;

  // Restoring step on the magnitudes; the trial MSB is the borrow.
  always_comb begin
    r_sh  = {r[p_nbits-1:0], q[p_nbits-1]};
    trial = r_sh - {1'b0, d};
    if (!trial[p_nbits]) begin
      r_step = trial;
      q_step = {q[p_nbits-2:0], 1'b1};
    end else begin
      r_step = r_sh;
      q_step = {q[p_nbits-2:0], 1'b0};
    end
    res_q_nxt = div0 ? '1    : cond_neg(neg_q, q_step);
    res_r_nxt = div0 ? raw_a : cond_neg(neg_r, r_step[p_nbits-1:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    unique case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) state_nxt = CALC;
      end
      CALC: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      raw_a <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      res_q <= '0;
      res_r <= '0;
    end else if (accept) begin
      cnt   <= CW'(p_nbits);
      r     <= '0;
      q     <= cond_neg(sa, op_a);
      d     <= cond_neg(sb, op_b);
      raw_a <= op_a;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      div0  <= (op_b == '0);
    end else if (state == CALC) begin
      r   <= r_step;
      q   <= q_step;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        res_q <= res_q_nxt;
        res_r <= res_r_nxt;
      end
    end
  end

  assign ostream_msg = {res_r, res_q};

endmodule

// File: tb/tb_int_div_iterative.sv
// Bench for int_div_iterative: vector table, directed backpressure/reset
// sequences and a random soak, all checked through an expected-response queue.
module tb_int_div_iterative;

  localparam int N = 32;

  logic            clk;
  logic            reset_n;
  logic            istream_val;
  logic            istream_rdy;
  logic [2*N:0]    istream_msg;
  logic            ostream_val;
  logic            ostream_rdy;
  logic [2*N-1:0]  ostream_msg;

  int_div_iterative #(.p_nbits(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t        tbl [12];
  logic [63:0] exp_q [$];
  logic [63:0] cur_exp;
  int          n_vec, n_err;
  int          cyc, acc_cyc, hs_cyc;
  logic        prev_val, accepted, chk_acc, rand_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, uq, ur;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    ua = (s && a[31]) ? -a : a;
    ub = (s && b[31]) ? -b : b;
    uq = ua / ub;
    ur = ua % ub;
    if (s && (a[31] ^ b[31])) uq = -uq;
    if (s && a[31]) ur = -ur;
    return {ur, uq};
  endfunction

  // Observe at the falling edge, then advance to just after the rising edge.
  task automatic tick();
    accepted = 1'b0;
    @(negedge clk);
    if (!reset_n) begin
      exp_q.delete();
      prev_val = 1'b0;
    end else begin
      if (ostream_val && !prev_val) check("latency", 64'(cyc - acc_cyc), 64'(N + 1));
      if (ostream_val && ostream_rdy) begin
        if (exp_q.size() == 0) fail("unexpected_response");
        else check("resp", ostream_msg, exp_q.pop_front());
        hs_cyc = cyc;
      end
      if (istream_val && istream_rdy) begin
        exp_q.push_back(cur_exp);
        acc_cyc  = cyc;
        accepted = 1'b1;
        if (chk_acc) check("accept_after_handshake", 64'(cyc), 64'(hs_cyc + 1));
      end
      prev_val = ostream_val;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rand_rdy) ostream_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    logic done;
    done        = 1'b0;
    istream_val = 1'b1;
    istream_msg = {s, a, b};
    cur_exp     = exp;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = accepted;
    end
    istream_val = 1'b0;
    if (!done) fail("accept_timeout");
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_q.size() == 0 && !ostream_val) done = 1'b1;
      else tick();
    end
    if (!done) fail("drain_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        quiet;
    logic        s;
    logic [31:0] a, b;

    n_vec = 0; n_err = 0; cyc = 0; acc_cyc = 0; hs_cyc = 0;
    prev_val = 1'b0; accepted = 1'b0; chk_acc = 1'b0; rand_rdy = 1'b0;
    reset_n = 1'b0; istream_val = 1'b0; istream_msg = '0; ostream_rdy = 1'b1; cur_exp = '0;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    tbl[2]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    tbl[3]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    tbl[4]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
    tbl[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
    tbl[6]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB};
    tbl[7]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    tbl[8]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    tbl[9]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};
    tbl[10] = '{1'b1, 32'd7,          32'd2,          32'd3,          32'd1};
    tbl[11] = '{1'b0, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   32'd15};

    tick();
    tick();
    check("reset_istream_rdy", 64'(istream_rdy), 64'd1);
    check("reset_ostream_val", 64'(ostream_val), 64'd0);
    check("reset_ostream_msg", ostream_msg, 64'd0);
    reset_n = 1'b1;
    tick();

    // Table vectors back-to-back with the response side always ready.
    for (int i = 0; i < 12; i++)
      send(tbl[i].s, tbl[i].a, tbl[i].b, {tbl[i].r, tbl[i].q});
    drain();

    // Backpressure: response held five cycles while a second request waits.
    ostream_rdy = 1'b0;
    send(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100});
    for (int i = 0; i < 60 && !ostream_val; i++) tick();
    istream_val = 1'b1;
    istream_msg = {1'b0, 32'd50, 32'd7};
    cur_exp     = {32'd1, 32'd7};
    chk_acc     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ostream_val", 64'(ostream_val), 64'd1);
      check("bp_ostream_msg", ostream_msg, {32'd0, 32'd100});
      check("bp_istream_rdy", 64'(istream_rdy), 64'd0);
      tick();
    end
    ostream_rdy = 1'b1;
    begin
      logic done;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
        tick();
        done = accepted;
      end
      if (!done) fail("bp_second_accept");
    end
    istream_val = 1'b0;
    chk_acc     = 1'b0;
    drain();

    // Asynchronous reset between clock edges in the middle of a division.
    send(1'b0, 32'd1000000, 32'd3, {32'd1, 32'd333333});
    repeat (10) tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_istream_rdy", 64'(istream_rdy), 64'd1);
    check("async_rst_ostream_val", 64'(ostream_val), 64'd0);
    check("async_rst_ostream_msg", ostream_msg, 64'd0);
    tick();
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ostream_val) quiet = 1'b0;
      tick();
    end
    check("no_resp_after_reset", 64'(quiet), 64'd1);
    send(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
    drain();

    // Random soak with input gaps and output stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       a = 32'h80000000 | (a & 32'h0000000F);
        default: b = $urandom;
      endcase
      if (a == 32'h80000000 || a[31:4] == 28'h8000000) b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom;
      send(s, a, b, ref_div(s, a, b));
    end
    rand_rdy    = 1'b0;
    ostream_rdy = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
